pdm_sample_feeder: RTL and testbench

- Wishbone peripheral that buffers CPU-written audio samples in a small FIFO and delivers one sample per sample period to a downstream PDM channel.
- Delivery is a Wishbone controller write to the channel, which updates the channel's level register.
- Sits directly upstream of the PDM channel; decouples bursty CPU writes from a fixed sample rate set by a programmable divider.

---
 rtl/pdm_sample_feeder_pkg.sv | 34 +++
 rtl/pdm_sample_feeder_if.sv | 26 ++
 rtl/pdm_sample_feeder_fifo.sv | 60 ++++++
 rtl/pdm_sample_feeder.sv | 207 ++++++++++++++++++++
 tb/tb_pdm_sample_feeder.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pdm_sample_feeder_pkg.sv
// Shared definitions for the PDM sample feeder: register map, STATUS layout,
// channel-write FSM states and the STATUS byte builder.
package pdm_feeder_pkg;

  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_DIV_LO = 2'd1;
  localparam logic [1:0] ADR_DIV_HI = 2'd2;
  localparam logic [1:0] ADR_STATUS = 2'd3;

  localparam int STAT_OVF   = 7;
  localparam int STAT_UNF   = 6;
  localparam int STAT_LATE  = 5;
  localparam int STAT_FULL  = 4;
  localparam int STAT_EMPTY = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } feeder_state_e;

  function automatic logic [7:0] status_byte(input logic ovf, input logic unf,
                                             input logic late, input logic full,
                                             input logic empty);
    logic [7:0] s;
    s             = 8'h00;
    s[STAT_OVF]   = ovf;
    s[STAT_UNF]   = unf;
    s[STAT_LATE]  = late;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    return s;
  endfunction

endpackage

// File: rtl/pdm_sample_feeder_if.sv
// CPU-side Wishbone slave port plus the controller-side channel write port
// and interrupt of the sample feeder.
interface pdm_sample_feeder_if #(
  parameter int pBits = 8
);
  logic             wb_stb;
  logic             wb_we;
  logic [1:0]       wb_adr;
  logic [pBits-1:0] wb_dat_i;
  logic [pBits-1:0] wb_dat_o;
  logic             wb_ack;
  logic             ch_stb;
  logic [pBits-1:0] ch_dat;
  logic             ch_ack;
  logic             irq;

  modport slave (
    input  wb_stb, wb_we, wb_adr, wb_dat_i, ch_ack,
    output wb_dat_o, wb_ack, ch_stb, ch_dat, irq
  );

  modport master (
    output wb_stb, wb_we, wb_adr, wb_dat_i, ch_ack,
    input  wb_dat_o, wb_ack, ch_stb, ch_dat, irq
  );
endinterface

// File: rtl/pdm_sample_feeder_fifo.sv
// Synchronous show-ahead FIFO: head always presents the oldest stored sample.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fifo_sync #(
  parameter int pBits  = 8,
  parameter int pDepth = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [pBits-1:0]          din,
  output logic [pBits-1:0]          head,
  output logic [$clog2(pDepth):0]   count,
  output logic                      full,
  output logic                      empty
);
  localparam int AW    = $clog2(pDepth);
  localparam int CNT_W = AW + 1;

  logic [pBits-1:0] mem_r [pDepth];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < pDepth; i++) begin
        mem_r[i] <= {pBits{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CNT_W'(pDepth));
  assign empty = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/pdm_sample_feeder.sv
// Buffers CPU-written samples and writes one per divider period to the PDM
// channel; register decode, tick counter, sticky flags and channel FSM live here.
module pdm_sample_feeder
  import pdm_feeder_pkg::*;
#(
  parameter int pBits    = 8,
  parameter int pDepth   = 16,
  parameter int pDivBits = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pdm_sample_feeder_if.slave bus
);
  localparam int CNT_W = $clog2(pDepth) + 1;
  localparam int HI_W  = pDivBits - 8;
  localparam logic [CNT_W-1:0]    CNT_HALF = CNT_W'(pDepth / 2);
  localparam logic [pDivBits-1:0] DIV_ZERO = {pDivBits{1'b0}};

  logic                wb_ack_r;
  logic [pBits-1:0]    wb_dat_o_r;
  logic [pDivBits-1:0] div_r;
  logic [pDivBits-1:0] tick_cnt_r;
  logic                ovf_r;
  logic                unf_r;
  logic                late_r;
  logic                irq_r;
  feeder_state_e       state_r;
  logic                ch_stb_r;
  logic [pBits-1:0]    ch_dat_r;

  logic                bus_fire_s;
  logic                wr_s;
  logic                rd_s;
  logic                push_req_s;
  logic                push_s;
  logic                pop_s;
  logic                tick_s;
  logic                ovf_set_s;
  logic                unf_set_s;
  logic                late_set_s;
  logic                ovf_nxt_s;
  logic                unf_nxt_s;
  logic                late_nxt_s;
  logic                irq_nxt_s;
  logic                reload_s;
  logic [pDivBits-1:0] div_nxt_s;
  logic [pBits-1:0]    clr_s;
  logic [pBits-1:0]    rd_data_s;
  logic [CNT_W-1:0]    count_nxt_s;
  logic [pBits-1:0]    fifo_head_s;
  logic [CNT_W-1:0]    fifo_count_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;

  fifo_sync #(
    .pBits  (pBits),
    .pDepth (pDepth)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   (bus.wb_dat_i),
    .head  (fifo_head_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign bus_fire_s = bus.wb_stb & ~wb_ack_r;
  assign wr_s       = bus_fire_s & bus.wb_we;
  assign rd_s       = bus_fire_s & ~bus.wb_we;
  assign push_req_s = wr_s & (bus.wb_adr == ADR_DATA);

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign tick_s     = (div_r != DIV_ZERO) & (tick_cnt_r == DIV_ZERO);
  assign pop_s      = tick_s & (state_r == IDLE) & ~fifo_empty_s;
  assign unf_set_s  = tick_s & (state_r == IDLE) & fifo_empty_s;
  assign late_set_s = tick_s & (state_r == SEND);
  assign push_s     = push_req_s & (~fifo_full_s | pop_s);
  assign ovf_set_s  = push_req_s & fifo_full_s & ~pop_s;

  assign ovf_nxt_s  = ovf_set_s  | (ovf_r  & ~clr_s[STAT_OVF]);
  assign unf_nxt_s  = unf_set_s  | (unf_r  & ~clr_s[STAT_UNF]);
  assign late_nxt_s = late_set_s | (late_r & ~clr_s[STAT_LATE]);
  assign irq_nxt_s  = (count_nxt_s <= CNT_HALF) | ovf_nxt_s | unf_nxt_s | late_nxt_s;

  // Register writes: divider bytes and STATUS clear mask
  always_comb begin
    div_nxt_s = div_r;
    reload_s  = 1'b0;
    clr_s     = {pBits{1'b0}};
    if (wr_s) begin
      case (bus.wb_adr)
        ADR_DIV_LO: begin
          div_nxt_s[7:0] = bus.wb_dat_i[7:0];
          reload_s       = 1'b1;
        end
        ADR_DIV_HI: begin
          div_nxt_s[pDivBits-1:8] = bus.wb_dat_i[HI_W-1:0];
          reload_s                = 1'b1;
        end
        ADR_STATUS: clr_s = bus.wb_dat_i;
        default:    clr_s = {pBits{1'b0}};
      endcase
    end else begin
      reload_s = 1'b0;
    end
  end

  // Register read mux
  always_comb begin
    rd_data_s = {pBits{1'b0}};
    case (bus.wb_adr)
      ADR_DIV_LO: rd_data_s[7:0]      = div_r[7:0];
      ADR_DIV_HI: rd_data_s[HI_W-1:0] = div_r[pDivBits-1:8];
      ADR_STATUS: rd_data_s[7:0]      = status_byte(ovf_r, unf_r, late_r,
                                                    fifo_full_s, fifo_empty_s);
      default:    rd_data_s           = {pBits{1'b0}};
    endcase
  end

  // Post-edge FIFO occupancy, used so irq tracks the count without lag
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = fifo_count_s + CNT_W'(1'b1);
      2'b01:   count_nxt_s = fifo_count_s - CNT_W'(1'b1);
      default: count_nxt_s = fifo_count_s;
    endcase
  end

  // Bus response, divider, sticky flags and interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_r   <= 1'b0;
      wb_dat_o_r <= {pBits{1'b0}};
      div_r      <= DIV_ZERO;
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
      late_r     <= 1'b0;
      irq_r      <= 1'b1;
    end else begin
      wb_ack_r   <= bus_fire_s;
      wb_dat_o_r <= rd_s ? rd_data_s : {pBits{1'b0}};
      div_r      <= div_nxt_s;
      ovf_r      <= ovf_nxt_s;
      unf_r      <= unf_nxt_s;
      late_r     <= late_nxt_s;
      irq_r      <= irq_nxt_s;
    end
  end

  // Sample-period down-counter; a divider write restarts the period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= DIV_ZERO;
    end else if (reload_s) begin
      tick_cnt_r <= div_nxt_s;
    end else if (div_r == DIV_ZERO) begin
      tick_cnt_r <= DIV_ZERO;
    end else if (tick_cnt_r == DIV_ZERO) begin
      tick_cnt_r <= div_r;
    end else begin
      tick_cnt_r <= tick_cnt_r - pDivBits'(1'b1);
    end
  end

  // Channel write FSM: ch_dat holds the last delivered sample after the ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      ch_stb_r <= 1'b0;
      ch_dat_r <= {pBits{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            ch_dat_r <= fifo_head_s;
            ch_stb_r <= 1'b1;
            state_r  <= SEND;
          end else begin
            ch_stb_r <= 1'b0;
          end
        end
        SEND: begin
          if (bus.ch_ack) begin
            ch_stb_r <= 1'b0;
            state_r  <= IDLE;
          end else begin
            ch_stb_r <= 1'b1;
          end
        end
        default: begin
          ch_stb_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign bus.wb_ack   = wb_ack_r;
  assign bus.wb_dat_o = wb_dat_o_r;
  assign bus.ch_stb   = ch_stb_r;
  assign bus.ch_dat   = ch_dat_r;
  assign bus.irq      = irq_r;

endmodule

// File: tb/tb_pdm_sample_feeder.sv
// Self-checking bench for pdm_sample_feeder: a queue-based reference model is
// compared against the DUT outputs every cycle, plus directed literal checks.
module tb_pdm_sample_feeder;
  import pdm_feeder_pkg::*;

  localparam int PB   = 8;
  localparam int PD   = 16;
  localparam int PDIV = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pdm_sample_feeder_if #(.pBits(PB)) bus ();

  pdm_sample_feeder #(
    .pBits    (PB),
    .pDepth   (PD),
    .pDivBits (PDIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  byte unsigned q[$];
  int  m_div, m_cnt, m_cur, m_dato;
  bit  m_busy, m_ovf, m_unf, m_late, m_ack;

  function automatic void model_reset();
    q.delete();
    m_div = 0; m_cnt = 0; m_cur = 0; m_dato = 0;
    m_busy = 0; m_ovf = 0; m_unf = 0; m_late = 0; m_ack = 0;
  endfunction

  function automatic int status_model();
    return (m_ovf ? 128 : 0) + (m_unf ? 64 : 0) + (m_late ? 32 : 0) +
           ((q.size() == PD) ? 16 : 0) + ((q.size() == 0) ? 8 : 0);
  endfunction

  function automatic void model_step();
    bit fire, tick, pop, push_req, push_ok, ovf_s, unf_s, late_s, wr;
    int rd, newdiv, adr, dat, clr;
    adr      = int'(bus.wb_adr);
    dat      = int'(bus.wb_dat_i);
    fire     = bus.wb_stb && !m_ack;
    wr       = fire && bus.wb_we;
    tick     = (m_div != 0) && (m_cnt == 0);
    pop      = tick && !m_busy && (q.size() != 0);
    unf_s    = tick && !m_busy && (q.size() == 0);
    late_s   = tick && m_busy;
    push_req = wr && (adr == 0);
    push_ok  = push_req && ((q.size() < PD) || pop);
    ovf_s    = push_req && !push_ok;
    case (adr)
      1:       rd = m_div % 256;
      2:       rd = m_div / 256;
      3:       rd = status_model();
      default: rd = 0;
    endcase
    m_dato = (fire && !bus.wb_we) ? rd : 0;
    m_ack  = fire;
    clr    = (wr && adr == 3) ? dat : 0;
    m_ovf  = ovf_s  || (m_ovf  && clr[7] == 1'b0);
    m_unf  = unf_s  || (m_unf  && clr[6] == 1'b0);
    m_late = late_s || (m_late && clr[5] == 1'b0);
    newdiv = m_div;
    if (wr && adr == 1) newdiv = (m_div / 256) * 256 + dat;
    if (wr && adr == 2) newdiv = dat * 256 + (m_div % 256);
    if (wr && (adr == 1 || adr == 2)) m_cnt = newdiv;
    else if (tick)                    m_cnt = m_div;
    else if (m_cnt > 0)               m_cnt = m_cnt - 1;
    m_div = newdiv;
    if (m_busy) begin
      if (bus.ch_ack) m_busy = 0;
    end else if (pop) begin
      m_cur  = q.pop_front();
      m_busy = 1;
    end
    if (push_ok) q.push_back(byte'(dat));
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("wb_ack",   bus.wb_ack,   m_ack);
      check("wb_dat_o", bus.wb_dat_o, m_dato);
      check("ch_stb",   bus.ch_stb,   m_busy);
      check("ch_dat",   bus.ch_dat,   m_cur);
      check("irq",      bus.irq,      (q.size() <= PD / 2) || m_ovf || m_unf || m_late);
    end
  end

  // ---------------- channel responder and delivery monitor ----------------
  int  ack_delay = 1;
  bit  rand_ack  = 0;
  int  hold      = 0;
  int  cur_delay = 1;
  int  n_acks    = 0;
  int  cyc       = 0;
  bit  prev_stb  = 0;
  int  dlog[$];
  int  tlog[$];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.ch_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.ch_stb && !prev_stb) begin
        dlog.push_back(int'(bus.ch_dat));
        tlog.push_back(cyc);
      end
      prev_stb = rst_n && bus.ch_stb;
      if (!rst_n || !bus.ch_stb) begin
        hold       = 0;
        bus.ch_ack = 1'b0;
      end else begin
        if (hold == 0) cur_delay = rand_ack ? int'($urandom_range(1, 4)) : ack_delay;
        hold++;
        if (hold == cur_delay) n_acks++;
        bus.ch_ack = (hold >= cur_delay);
      end
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wb_xfer(input bit we, input logic [1:0] a, input logic [7:0] d,
                         output logic [7:0] rdat);
    bit got;
    got = 0;
    @(negedge clk);
    bus.wb_stb = 1'b1; bus.wb_we = we; bus.wb_adr = a; bus.wb_dat_i = d;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (bus.wb_ack) begin
        got = 1;
        break;
      end
    end
    rdat = bus.wb_dat_o;
    bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
    check("wb_ack_seen", got, 1);
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    wb_xfer(1'b1, a, d, dummy);
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [7:0] d);
    wb_xfer(1'b0, a, 8'h00, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dlog.delete();
    tlog.delete();
    n_acks = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rv;
    int exp_q[$];
    bit seen;

    bus.wb_stb = 1'b0; bus.wb_we = 1'b0; bus.wb_adr = 2'd0; bus.wb_dat_i = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_wb_ack", bus.wb_ack, 0);
    check("rst_wb_dat", bus.wb_dat_o, 0);
    check("rst_ch_stb", bus.ch_stb, 0);
    check("rst_ch_dat", bus.ch_dat, 0);
    check("rst_irq",    bus.irq, 1);

    // Divider stopped: a stored sample is never delivered
    wb_write(ADR_DATA, 8'h10);
    repeat (20) @(negedge clk);
    check("div0_no_stb", dlog.size(), 0);
    wb_read(ADR_STATUS, rv);
    check("div0_status", rv, 8'h00);
    check("div0_irq", bus.irq, 1);

    // DIV=3, immediate ack: one sample every 4 cycles, then underflow
    do_reset();
    ack_delay = 1;
    wb_write(ADR_DATA, 8'h11);
    wb_write(ADR_DATA, 8'h22);
    wb_write(ADR_DATA, 8'h33);
    wb_write(ADR_DIV_LO, 8'd3);
    repeat (30) @(negedge clk);
    check("div3_count", dlog.size(), 3);
    if (dlog.size() == 3) begin
      check("div3_s0", dlog[0], 8'h11);
      check("div3_s1", dlog[1], 8'h22);
      check("div3_s2", dlog[2], 8'h33);
      check("div3_gap0", tlog[1] - tlog[0], 4);
      check("div3_gap1", tlog[2] - tlog[1], 4);
    end
    check("div3_hold", bus.ch_dat, 8'h33);
    wb_read(ADR_STATUS, rv);
    check("div3_status", rv, 8'h48);
    wb_write(ADR_DIV_LO, 8'd0);

    // Overflow on the 17th push, then clear OVF only
    do_reset();
    for (int i = 0; i < 17; i++) wb_write(ADR_DATA, 8'(i + 1));
    wb_read(ADR_STATUS, rv);
    check("ovf_status", rv, 8'h90);
    wb_write(ADR_STATUS, 8'h80);
    wb_read(ADR_STATUS, rv);
    check("ovf_cleared", rv, 8'h10);
    check("ovf_irq", bus.irq, 0);

    // DIV=1 with slow channel: samples intact, ticks during SEND flag LATE
    do_reset();
    ack_delay = 5;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(int'($urandom_range(0, 255)));
      wb_write(ADR_DATA, 8'(exp_q[i]));
    end
    wb_write(ADR_DIV_LO, 8'd1);
    repeat (60) @(negedge clk);
    check("late_count", dlog.size(), 4);
    for (int i = 0; i < 4 && i < dlog.size(); i++) check("late_sample", dlog[i], exp_q[i]);
    check("late_acks", n_acks, 4);
    wb_read(ADR_STATUS, rv);
    check("late_flag", rv[5], 1);
    ack_delay = 1;
    wb_write(ADR_DIV_LO, 8'd0);

    // Asynchronous reset in the middle of a channel write
    do_reset();
    ack_delay = 20;
    wb_write(ADR_DATA, 8'h5A);
    wb_write(ADR_DIV_LO, 8'd1);
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.ch_stb) begin
        seen = 1;
        break;
      end
    end
    check("areset_send_seen", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_ch_stb", bus.ch_stb, 0);
    check("areset_ch_dat", bus.ch_dat, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 1;
    wb_read(ADR_DIV_LO, rv);
    check("areset_div_lo", rv, 8'h00);
    wb_read(ADR_STATUS, rv);
    check("areset_status", rv, 8'h08);

    // Full FIFO: push coincides with a tick-driven pop
    do_reset();
    for (int i = 0; i < PD; i++) wb_write(ADR_DATA, 8'(8'hA0 + i));
    wb_write(ADR_DIV_LO, 8'd1);
    wb_write(ADR_DATA, 8'hEE);
    wb_read(ADR_STATUS, rv);
    check("full_pushpop_status", rv, 8'h10);
    wb_write(ADR_DIV_LO, 8'd0);

    // Randomised traffic against the model
    do_reset();
    rand_ack = 1;
    for (int k = 0; k < 300; k++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 3)      wb_write(ADR_DATA, 8'($urandom_range(0, 255)));
      else if (op == 4) wb_write(ADR_DIV_LO, 8'($urandom_range(0, 6)));
      else if (op == 5) wb_write(ADR_DIV_HI, 8'h00);
      else if (op == 6) wb_write(ADR_STATUS, 8'($urandom_range(0, 255)));
      else              wb_read(2'($urandom_range(0, 3)), rv);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rand_ack = 0;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
